// File: rtl/calc_core_pkg.sv
// Shared definitions for the accumulator calculator core: bus levels,
// opcodes, FSM encoding and instruction field helpers.
package calc_core_pkg;

   localparam int WORD_W = 18;
   localparam int ADDR_W = 15;

   typedef logic [WORD_W-1:0] word_t;

   localparam logic READ    = 1'b0;
   localparam logic WRITE   = 1'b1;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_STORE = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_MUL   = 3'b100,
      OP_JMP   = 3'b101,
      OP_JZ    = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      DECODE  = 2'd1,
      EXECUTE = 2'd2,
      HALT    = 2'd3
   } state_t;

   function automatic opcode_t instrOp(input word_t instr);
      return opcode_t'(instr[WORD_W-1:ADDR_W]);
   endfunction

   // Operand address is zero-extended to a full word address.
   function automatic word_t instrAddr(input word_t instr);
      return {{(WORD_W-ADDR_W){1'b0}}, instr[ADDR_W-1:0]};
   endfunction

   function automatic logic isMemOperand(input opcode_t op);
      return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/calc_core_if.sv
// Memory command signals of the calculator core; the data bus itself is a
// plain tri-state port on the core.
interface calc_core_if;
   import calc_core_pkg::*;

   logic  memoryEnable;
   logic  memoryReadWrite;
   word_t memoryAddress;

   modport master (
      output memoryEnable,
      output memoryReadWrite,
      output memoryAddress
   );

   modport slave (
      input memoryEnable,
      input memoryReadWrite,
      input memoryAddress
   );

endinterface

// File: rtl/calc_core_alu.sv
// Combinational accumulator ALU: produces the next ACC value for memory
// operand instructions and the ACC==0 test used by JZ.
module calc_alu
   import calc_core_pkg::*;
(
   input  word_t   acc,
   input  word_t   operand,
   input  opcode_t opcode,
   output word_t   result,
   output logic    zero
);

   always_comb begin
      result = acc;
      case (opcode)
         OP_LOAD: result = operand;
         OP_ADD:  result = acc + operand;
         OP_SUB:  result = acc - operand;
         // 18-bit context keeps only the low half of the product.
         OP_MUL:  result = acc * operand;
         default: result = acc;
      endcase
   end

   assign zero = (acc == '0);

endmodule

// File: rtl/calc_core.sv
// Multicycle accumulator calculator: fetches, decodes and executes 18-bit
// instructions over a single shared asynchronous-read memory port.
//
//   state   | meaning
//   FETCH   | read M[PC] into IR, PC+1
//   DECODE  | no memory access; pick EXECUTE or HALT
//   EXECUTE | memory operand access, store, or jump
//   HALT    | frozen until reset
module calc_core
   import calc_core_pkg::*;
#(
   parameter word_t RESET_ADDRESS = '0
) (
   input  logic              clk,
   input  logic              reset,
   inout  wire [WORD_W-1:0]  memoryData,
   calc_core_if.master       mem
);

   state_t  state;
   state_t  nextState;
   word_t   pc;
   word_t   ir;
   word_t   acc;
   logic    running;

   opcode_t op;
   word_t   operandAddr;
   word_t   aluResult;
   logic    accZero;

   logic    memEnable;
   logic    memRw;
   word_t   memAddr;
   logic    driveBus;

   assign op          = instrOp(ir);
   assign operandAddr = instrAddr(ir);

   calc_alu u_alu (
      .acc     (acc),
      .operand (memoryData),
      .opcode  (op),
      .result  (aluResult),
      .zero    (accZero)
   );

   // running holds the core quiet for the cycle in which reset is still
   // asserted, so the first real FETCH is the cycle after release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= FETCH;
         running <= 1'b0;
      end else begin
         running <= 1'b1;
         if (running) begin
            state <= nextState;
         end
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         FETCH:   nextState = DECODE;
         DECODE:  nextState = (op == OP_HALT) ? HALT : EXECUTE;
         EXECUTE: nextState = FETCH;
         HALT:    nextState = HALT;
         default: nextState = FETCH;
      endcase
   end

   always_comb begin
      memEnable = DISABLE;
      memRw     = READ;
      memAddr   = '0;
      driveBus  = 1'b0;
      if (running) begin
         case (state)
            FETCH: begin
               memEnable = ENABLE;
               memAddr   = pc;
            end
            EXECUTE: begin
               if (isMemOperand(op)) begin
                  memEnable = ENABLE;
                  memAddr   = operandAddr;
               end else if (op == OP_STORE) begin
                  memEnable = ENABLE;
                  memRw     = WRITE;
                  memAddr   = operandAddr;
                  driveBus  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc  <= RESET_ADDRESS;
         ir  <= '0;
         acc <= '0;
      end else if (running) begin
         case (state)
            FETCH: begin
               ir <= memoryData;
               pc <= pc + word_t'(1);
            end
            EXECUTE: begin
               if (isMemOperand(op)) begin
                  acc <= aluResult;
               end else if (op == OP_JMP) begin
                  pc <= operandAddr;
               end else if ((op == OP_JZ) && accZero) begin
                  pc <= operandAddr;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem.memoryEnable    = memEnable;
   assign mem.memoryReadWrite = memRw;
   assign mem.memoryAddress   = memAddr;
   assign memoryData          = driveBus ? acc : {WORD_W{1'bz}};

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core: expected memory accesses are queued per
// program and a monitor compares every access the core presents.
module tb_calc_core;
   import calc_core_pkg::*;

   typedef struct {
      logic        rw;
      logic [17:0] addr;
      logic [17:0] data;
      int          cyc;
   } access_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   wire  [17:0] memoryData;
   calc_core_if bus ();

   calc_core dut (
      .clk        (clk),
      .reset      (reset),
      .memoryData (memoryData),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   logic [17:0] memArr [0:63];
   access_t     expQ [$];
   int          nTests = 0;
   int          nFail = 0;
   int          cyc = 0;
   logic        chkEn = 1'b0;
   logic        wrSeen = 1'b0;
   logic [17:0] wrAddr = '0;
   logic [17:0] wrData = '0;

   logic        coreWrites;
   logic [17:0] tbDrive;

   // When the core is not writing, the bench drives either read data or an
   // alternating idle pattern, so any stray core drive corrupts the bus value.
   assign coreWrites = bus.memoryEnable && (bus.memoryReadWrite == WRITE);
   assign tbDrive    = (bus.memoryEnable && (bus.memoryReadWrite == READ))
                       ? memArr[bus.memoryAddress[5:0]]
                       : (cyc[0] ? 18'h2AAAA : 18'h15555);
   assign memoryData = coreWrites ? 18'bz : tbDrive;

   always @(posedge clk) begin
      if (reset && wrSeen) memArr[wrAddr[5:0]] = wrData;
      if (!reset) cyc = 0;
      else cyc = cyc + 1;
   end

   always @(negedge clk) begin
      access_t e;
      if (chkEn) begin
         if (!coreWrites) begin
            nTests++;
            if (memoryData !== tbDrive) begin
               nFail++;
               $display("FAIL busDrive cyc=%0d: bus=%h need %h", cyc, memoryData, tbDrive);
            end
         end
         if (!bus.memoryEnable) begin
            nTests++;
            if (bus.memoryAddress !== 18'h0) begin
               nFail++;
               $display("FAIL idleAddr cyc=%0d: addr=%h need 0", cyc, bus.memoryAddress);
            end
         end else if (expQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("FAIL unexpectedAccess cyc=%0d: rw=%0d addr=%h, need no access",
                     cyc, bus.memoryReadWrite, bus.memoryAddress);
         end else begin
            e = expQ.pop_front();
            nTests++;
            if ((bus.memoryReadWrite !== e.rw) || (bus.memoryAddress !== e.addr) ||
                (cyc != e.cyc) || ((e.rw == WRITE) && (memoryData !== e.data))) begin
               nFail++;
               $display("FAIL access: got rw=%0d addr=%h data=%h cyc=%0d, need rw=%0d addr=%h data=%h cyc=%0d",
                        bus.memoryReadWrite, bus.memoryAddress, memoryData, cyc,
                        e.rw, e.addr, e.data, e.cyc);
            end
         end
      end
      wrSeen = coreWrites;
      wrAddr = bus.memoryAddress;
      wrData = memoryData;
   end

   function automatic logic [17:0] enc(input logic [2:0] op, input int a);
      return {op, a[14:0]};
   endfunction

   task automatic expRd(input int a, input int c);
      access_t e;
      e.rw = READ; e.addr = 18'(a); e.data = '0; e.cyc = c;
      expQ.push_back(e);
   endtask

   task automatic expWr(input int a, input logic [17:0] d, input int c);
      access_t e;
      e.rw = WRITE; e.addr = 18'(a); e.data = d; e.cyc = c;
      expQ.push_back(e);
   endtask

   task automatic clearMem();
      for (int i = 0; i < 64; i++) memArr[i] = '0;
   endtask

   task automatic check(input string name, input logic [17:0] got, input logic [17:0] need);
      nTests++;
      if (got !== need) begin
         nFail++;
         $display("FAIL %s: got %h need %h", name, got, need);
      end
   endtask

   task automatic enterReset(input int n);
      reset = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drainAndHalt(input string name);
      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      check({name, "_drained"}, 18'(expQ.size()), 18'h0);
      check({name, "_haltEnable"}, {17'h0, bus.memoryEnable}, 18'h0);
      check({name, "_haltAddr"}, bus.memoryAddress, 18'h0);
      expQ.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      clearMem();
      repeat (2) @(negedge clk);
      chkEn = 1'b1;

      // Basic program, reset held 5 cycles first.
      memArr[0]  = enc(3'b000, 10);
      memArr[1]  = enc(3'b010, 11);
      memArr[2]  = enc(3'b001, 12);
      memArr[3]  = enc(3'b111, 0);
      memArr[10] = 18'd5;
      memArr[11] = 18'd7;
      expRd(0, 1);  expRd(10, 3);
      expRd(1, 4);  expRd(11, 6);
      expRd(2, 7);  expWr(12, 18'd12, 9);
      expRd(3, 10);
      repeat (5) @(negedge clk);
      check("resetEnable", {17'h0, bus.memoryEnable}, 18'h0);
      reset = 1'b1;
      drainAndHalt("prog1");
      check("prog1_m12", memArr[12], 18'd12);

      // SUB/MUL wrap.
      enterReset(3);
      clearMem();
      memArr[0]  = enc(3'b000, 20);
      memArr[1]  = enc(3'b011, 21);
      memArr[2]  = enc(3'b001, 30);
      memArr[3]  = enc(3'b100, 22);
      memArr[4]  = enc(3'b001, 31);
      memArr[5]  = enc(3'b111, 0);
      memArr[20] = 18'd3;
      memArr[21] = 18'd5;
      memArr[22] = 18'd2;
      expRd(0, 1);  expRd(20, 3);
      expRd(1, 4);  expRd(21, 6);
      expRd(2, 7);  expWr(30, 18'h3FFFE, 9);
      expRd(3, 10); expRd(22, 12);
      expRd(4, 13); expWr(31, 18'h3FFFC, 15);
      expRd(5, 16);
      reset = 1'b1;
      drainAndHalt("wrap");
      check("wrap_sub", memArr[30], 18'h3FFFE);
      check("wrap_mul", memArr[31], 18'h3FFFC);

      // JZ taken, JZ not taken, JMP back to 0.
      enterReset(3);
      clearMem();
      memArr[0]  = enc(3'b110, 20);
      memArr[1]  = enc(3'b111, 0);
      memArr[20] = enc(3'b000, 40);
      memArr[21] = enc(3'b110, 0);
      memArr[22] = enc(3'b001, 41);
      memArr[23] = enc(3'b101, 0);
      memArr[40] = 18'd9;
      expRd(0, 1);
      expRd(20, 4); expRd(40, 6);
      expRd(21, 7);
      expRd(22, 10); expWr(41, 18'd9, 12);
      expRd(23, 13);
      expRd(0, 16);
      expRd(1, 19);
      reset = 1'b1;
      drainAndHalt("jump");

      // Reset asserted in the EXECUTE cycle of a STORE.
      enterReset(3);
      clearMem();
      memArr[0]  = enc(3'b000, 10);
      memArr[1]  = enc(3'b001, 12);
      memArr[2]  = enc(3'b111, 0);
      memArr[10] = 18'd5;
      memArr[12] = 18'h00777;
      expRd(0, 1); expRd(10, 3);
      expRd(1, 4); expWr(12, 18'd5, 6);
      reset = 1'b1;
      for (int i = 0; i < 50 && !coreWrites; i++) @(negedge clk);
      check("midStoreSeen", {17'h0, coreWrites}, 18'h1);
      reset = 1'b0;
      @(negedge clk);
      check("abandonEnable", {17'h0, bus.memoryEnable}, 18'h0);
      check("abandonQueue", 18'(expQ.size()), 18'h0);
      repeat (3) @(negedge clk);
      memArr[0]  = enc(3'b001, 13);
      memArr[1]  = enc(3'b111, 0);
      memArr[13] = 18'h01234;
      expRd(0, 1); expWr(13, 18'h0, 3);
      expRd(1, 4);
      reset = 1'b1;
      drainAndHalt("afterReset");
      check("targetKept", memArr[12], 18'h00777);
      check("accCleared", memArr[13], 18'h0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
